// File: rtl/f11_qbus_seq.sv
// Q-bus cycle sequencer: runs DATI/DATO/DATOB/DATIO handshakes, stalls the microsequencer,
// arbitrates DMA between CPU cycles. Optional RPLY timeout under `F11_QBUS_TOUT_EN`.
module f11_qbus_seq #(
    parameter int unsigned   AW   = 22,
    parameter int unsigned   DW   = 16,
    parameter int unsigned   TW   = 8,
    parameter logic [TW-1:0] TOUT = 8'd200
) (
    input  logic          pin_clk,
    input  logic          pin_rst,
    input  logic          cmd_req,
    input  logic [2:0]    cmd_m,
    input  logic [AW-1:0] cmd_adr,
    input  logic [DW-1:0] cmd_dat,
    input  logic          cmd_byte,
    input  logic          dma_req,
    input  logic          rply,
    input  logic [DW-1:0] bus_rdat,
    output logic          bus_ad_oe,
    output logic [AW-1:0] bus_adr,
    output logic [DW-1:0] bus_dat,
    output logic          bus_sync,
    output logic          bus_din,
    output logic          bus_dout,
    output logic          bus_wtbt,
    output logic [DW-1:0] rd_dat,
    output logic          dma_gnt,
    output logic          clk_hold,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        StIdle, StAdr, StDin, StDinw, StDout, StDoutw, StEnd, StDma
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    op_q;
    logic          byte_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic [DW-1:0] rd_dat_q;
    logic          accept;
    logic          is_datio;
    logic          wtbt_data;
    logic          tout_hit;

    // op_q encodes {m9,m8}: 00 DATO, 01 DATOB, 10 DATI, 11 DATIO
    assign accept    = (state_q == StIdle) && !dma_req && cmd_req && cmd_m[2];
    assign is_datio  = (op_q == 2'b11);
    assign wtbt_data = (op_q == 2'b01) || (is_datio && byte_q);

    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            op_q     <= 2'b00;
            byte_q   <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            rd_dat_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= cmd_m[1:0];
                byte_q <= cmd_byte;
                adr_q  <= cmd_adr;
                dat_q  <= cmd_dat;
            end
            if (state_q == StDin && rply) begin
                rd_dat_q <= bus_rdat;
            end
        end
    end

`ifdef F11_QBUS_TOUT_EN
    localparam logic [TW-1:0] TOUT_LAST = TOUT - 1'b1;

    logic [TW-1:0] tout_cnt_q;
    logic          err_q;
    logic          waiting;
    logic          tout_fire;

    assign waiting  = (state_q == StDin) || (state_q == StDinw) ||
                      (state_q == StDout) || (state_q == StDoutw);
    assign tout_hit = (tout_cnt_q == TOUT_LAST);

    // Expiry only counts when the handshake did not complete on the same edge
    always_comb begin
        tout_fire = 1'b0;
        unique case (state_q)
            StDin, StDout:   tout_fire = tout_hit && !rply;
            StDinw, StDoutw: tout_fire = tout_hit && rply;
            default:         tout_fire = 1'b0;
        endcase
    end

    // Each wait phase gets its own budget: the count restarts on every state change
    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            tout_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= tout_fire;
            if (state_d != state_q) begin
                tout_cnt_q <= '0;
            end else if (waiting) begin
                tout_cnt_q <= tout_cnt_q + 1'b1;
            end
        end
    end

    assign err = (state_q == StEnd) && err_q;
`else
    assign tout_hit = 1'b0;
    assign err      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (dma_req) begin
                    state_d = StDma;
                end else if (cmd_req && cmd_m[2]) begin
                    state_d = StAdr;
                end
            end
            StAdr:  state_d = op_q[1] ? StDin : StDout;
            StDin: begin
                if (rply) begin
                    state_d = StDinw;
                end else if (tout_hit) begin
                    state_d = StEnd;
                end
            end
            StDinw: begin
                if (!rply) begin
                    state_d = is_datio ? StDout : StEnd;
                end else if (tout_hit) begin
                    state_d = StEnd;
                end
            end
            StDout: begin
                if (rply || tout_hit) begin
                    state_d = rply ? StDoutw : StEnd;
                end
            end
            StDoutw: begin
                if (!rply || tout_hit) begin
                    state_d = StEnd;
                end
            end
            StEnd:  state_d = StIdle;
            StDma: begin
                if (!dma_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_ad_oe = 1'b0;
        bus_sync  = 1'b0;
        bus_din   = 1'b0;
        bus_dout  = 1'b0;
        bus_wtbt  = 1'b0;
        dma_gnt   = 1'b0;
        clk_hold  = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: ;
            StAdr: begin
                bus_ad_oe = 1'b1;
                bus_wtbt  = !op_q[1];
                clk_hold  = 1'b1;
            end
            StDin: begin
                bus_sync = 1'b1;
                bus_din  = 1'b1;
                clk_hold = 1'b1;
            end
            StDinw: begin
                bus_sync = 1'b1;
                clk_hold = 1'b1;
            end
            StDout: begin
                bus_sync  = 1'b1;
                bus_ad_oe = 1'b1;
                bus_dout  = 1'b1;
                bus_wtbt  = wtbt_data;
                clk_hold  = 1'b1;
            end
            StDoutw: begin
                bus_sync  = 1'b1;
                bus_ad_oe = 1'b1;
                bus_wtbt  = wtbt_data;
                clk_hold  = 1'b1;
            end
            StEnd:  done = 1'b1;
            StDma: begin
                dma_gnt  = 1'b1;
                clk_hold = cmd_req && cmd_m[2];
            end
            default: ;
        endcase
    end

    assign bus_adr = adr_q;
    assign bus_dat = dat_q;
    assign rd_dat  = rd_dat_q;

endmodule

// File: doc/f11_qbus_seq.md
Name: f11_qbus_seq

Overview:
- Parametrised successor to the KDF-11A bus-control decode: a clocked Q-bus cycle sequencer. It takes the microword bus-control field (m12/m9/m8 equivalent) and runs complete DATI/DATO/DATOB/DATIO cycles with the SYNC/DIN/DOUT/RPLY handshake.
- Sits between the microsequencer and the Q-bus pin drivers.
- Generates the microsequencer clock-hold (stutter) and arbitrates DMA requests between CPU cycles.

Parameters:
- AW, 22, address width in bits (16, 18 or 22).
- DW, 16, data width in bits.
- TW, 8, width of the RPLY timeout counter.
- TOUT, 8'd200, RPLY timeout in clocks (only used with F11_QBUS_TOUT_EN).

Ports:
- pin_clk  in  1  system clock; all logic is on the rising edge.
- pin_rst  in  1  reset, synchronous and active-high.
- cmd_req  in  1  microcode requests a bus cycle; sampled only in IDLE.
- cmd_m  in  3  {m12,m9,m8}. 1_00=DATO, 1_01=DATOB, 1_10=DATI, 1_11=DATIO; 0_xx=no bus cycle.
- cmd_adr  in  AW  cycle address; latched at accept.
- cmd_dat  in  DW  write data; latched at accept.
- dma_req  in  1  DMA request from the bus.
- rply  in  1  bus RPLY, already synchronised, active-high.
- bus_ad_oe  out  1  drive the address/data lines.
- bus_adr  out  AW  latched address.
- bus_dat  out  DW  latched write data.
- bus_sync  out  1  SYNC.
- bus_din  out  1  DIN.
- bus_dout  out  1  DOUT.
- bus_wtbt  out  1  WTBT.
- rd_dat  out  DW  read data captured on RPLY.
- dma_gnt  out  1  DMA grant.
- clk_hold  out  1  stall the microsequencer.
- done  out  1  one-clock pulse at end of a cycle.
- err  out  1  one-clock pulse on RPLY timeout.

Behaviour:
- Reset: all outputs 0, rd_dat=0, FSM=IDLE. Reset mid-cycle drops SYNC/DIN/DOUT on the next edge, with no done or err pulse.
- States: IDLE, ADR, DIN, DINW, DOUT, DOUTW, END, DMA.
- IDLE:
  - dma_req has priority: go to DMA and set dma_gnt the next clock.
  - Else cmd_req with cmd_m[2]=1: latch adr/dat/cmd and go to ADR. clk_hold=1 from this edge until the END exit.
  - cmd_req with cmd_m[2]=0: no bus activity and clk_hold stays 0.
- ADR (1 clk): bus_ad_oe=1 and address valid.
  - bus_wtbt=1 for DATO/DATOB.
  - Next clock: bus_sync=1 held until END. Go to DIN for DATI/DATIO, DOUT for DATO/DATOB.
- DIN: bus_ad_oe=0, bus_din=1 until rply=1 is sampled.
  - On that edge: rd_dat<=sampled data, din->0, go to DINW.
- DINW: wait for rply=0. Then go to DOUT if DATIO, else END.
- DOUT: bus_ad_oe=1 with data, bus_dout=1.
  - bus_wtbt=1 only for DATOB, and for DATIO only if the byte flag is set.
  - On rply=1: dout->0, go to DOUTW.
- DOUTW: wait for rply=0, then go to END.
- END (1 clk): sync->0, ad_oe->0, done=1 (pulse). clk_hold drops on this edge. Go to IDLE.
- DATIO keeps SYNC asserted across both DIN and DOUT phases.
- DMA: dma_gnt=1 while dma_req=1 and all bus outputs are 0.
  - clk_hold=1 if cmd_req is pending.
  - On dma_req=0: dma_gnt->0 and return to IDLE. A pending cmd_req is accepted the following clock.
- Simultaneous dma_req and cmd_req in IDLE: DMA wins.
- dma_req during a CPU cycle is ignored until IDLE.
- rply already high on entry to DIN/DOUT: the cycle completes on the first clock in that state (no minimum hold).
- The cmd_req level is ignored outside IDLE.

Optional Feature:
- Macro F11_QBUS_TOUT_EN.
- Defined:
  - A TW-bit counter clears on entry to DIN/DOUT and increments each clock while waiting for rply=1.
  - At count==TOUT-1: drop din/dout, pulse err=1 with done=1, go to END. rd_dat is left unchanged.
  - The counter also bounds DINW/DOUTW; on expiry there, go straight to END with err=1.
- Not defined: no counter logic, err tied to 0, and the FSM waits indefinitely.

Test Plan:
- DATI: cmd_m=3'b110, adr=22'o017777, rply rises 3 clk after DIN, data 16'o123456 -> SYNC high 1 clk after ADR, WTBT=0, rd_dat=16'o123456, done pulse once, clk_hold high for exactly the cycle.
- DATOB: cmd_m=3'b101, dat=16'h00A5 -> WTBT=1 in ADR and DOUT, DOUT drops on the clock after rply=1, done pulse, err=0.
- DATIO: cmd_m=3'b111 -> single SYNC spanning DIN then DOUT, rd_dat captured, DOUT only after rply has returned low.
- DMA priority: dma_req and cmd_req both asserted in IDLE -> dma_gnt=1 and clk_hold=1. After dma_req falls, the CPU cycle starts 2 clk later.
- Timeout (F11_QBUS_TOUT_EN, TOUT=8): DATI with no rply -> DIN high 8 clk, then err=1 and done=1 same clk, SYNC low, IDLE. Without the macro, err stays 0 and DIN stays high.
- Reset mid-DOUT -> next clock all outputs 0, no done, FSM=IDLE. A fresh DATO then completes normally.
